// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: frame-state encoding, default clocking
// constants and the bit-period derivation used by both directions.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, centre-sampling frame FSM, registered byte output.
// Optional UART_STOP_CHECK_EN drops frames whose stop bit reads low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_ready
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic              rx_meta;
    logic              rx_sync;
    uart_state_t       state;
    logic [CW-1:0]     cnt;
    logic [2:0]        idx;
    logic [7:0]        shift;
`ifdef UART_STOP_CHECK_EN
    logic              armed;
`endif

    // Two-flop synchroniser; resets to the idle line level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Frame FSM: start bit confirmed at half a bit, then one sample per bit centre
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            shift      <= 8'h00;
            data_out   <= 8'h00;
            data_ready <= 1'b0;
`ifdef UART_STOP_CHECK_EN
            armed      <= 1'b1;
`endif
        end else begin
            data_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    idx <= 3'd0;
`ifdef UART_STOP_CHECK_EN
                    // After a framing error the line must go high before a new start counts
                    if (!armed) begin
                        armed <= rx_sync;
                    end else if (!rx_sync) begin
                        state <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
`else
                    if (!rx_sync) begin
                        state <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
`endif
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
`ifdef UART_STOP_CHECK_EN
                        if (rx_sync) begin
                            data_out   <= shift;
                            data_ready <= 1'b1;
                        end else begin
                            armed <= 1'b0;
                        end
`else
                        data_out   <= shift;
                        data_ready <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: inline transmitter FSM plus the uart_rx receiver.
// UART_STOP_CHECK_EN (optional) enables stop-bit validation in the receiver.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       data_ready
);

    localparam int            CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int            CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    uart_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;

    // Transmit sequencer; tx and busy are driven straight from this register set
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= 3'd0;
            tx_shift <= 8'h00;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx_cnt <= '0;
                    tx_idx <= 3'd0;
                    if (send) begin
                        tx_shift <= data_in;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        tx_state <= ST_START;
                    end else begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            // Next bit is presented one shift ahead of the register update
                            tx       <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_idx   <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        busy     <= 1'b0;
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    tx_state <= ST_IDLE;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .data_ready(data_ready)
    );

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: frame-level reference model for both directions,
// randomized bytes/baud skew, plus literal expectations for the directed cases.
module tb_uart_top;

    localparam int CPB    = 434;
    localparam int FRAME  = 10 * CPB;
    localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       busy;
    logic [7:0] data_out;
    logic       data_ready;

    int checks = 0;
    int failures = 0;

    uart_top dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tx        (tx),
        .data_in   (data_in),
        .send      (send),
        .busy      (busy),
        .data_out  (data_out),
        .data_ready(data_ready)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures < 30) $display("FAIL %s got=%0h expected=%0h cycle=%0d", nm, got, exp, cyc);
        end
    endtask

    // Reference model state: edge counter, accepted TX frame, last reset edge
    int         cyc = 0;
    int         tx_start = -100000;
    int         next_ok = 0;
    logic [7:0] tx_byte = 8'h00;
    int         last_rst = -1;
    bit         chk_en = 1'b0;

    typedef struct {
        logic [7:0] b;
        int         due;
    } rx_exp_t;
    rx_exp_t    rxq[$];
    int         rx_rd = 0;
    logic [7:0] rx_last = 8'h00;
    int         ready_cnt = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        chk_en = 1'b1;
        if (rst) begin
            tx_start = -100000;
            next_ok  = 0;
            last_rst = cyc;
        end else if (send && cyc >= next_ok) begin
            tx_start = cyc;
            tx_byte  = data_in;
            next_ok  = cyc + FRAME + 1;
        end
    end

    int   k;
    logic exp_tx;
    logic exp_busy;

    // Every cycle: line level and busy from frame position, data_out from received frames
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            k = cyc - tx_start;
            if (k >= 0 && k < FRAME) begin
                exp_busy = 1'b1;
                if (k < CPB) exp_tx = 1'b0;
                else if (k >= 9 * CPB) exp_tx = 1'b1;
                else exp_tx = tx_byte[k / CPB - 1];
            end else begin
                exp_busy = 1'b0;
                exp_tx   = 1'b1;
            end
            chk("tx", 16'(tx), 16'(exp_tx));
            chk("busy", 16'(busy), 16'(exp_busy));
            if (last_rst == cyc) begin
                rx_rd   = rxq.size();
                rx_last = 8'h00;
            end
            if (data_ready === 1'b1) begin
                ready_cnt++;
                checks++;
                if (rx_rd >= rxq.size()) begin
                    failures++;
                    $display("FAIL rx_unexpected_ready got data_out=%0h expected no pulse cycle=%0d", data_out, cyc);
                end else begin
                    if (cyc < rxq[rx_rd].due - 2 || cyc > rxq[rx_rd].due + 2) begin
                        failures++;
                        $display("FAIL rx_latency got=%0d expected=%0d", cyc, rxq[rx_rd].due);
                    end
                    rx_last = rxq[rx_rd].b;
                    rx_rd++;
                end
            end else if (rx_rd < rxq.size() && cyc > rxq[rx_rd].due + 2) begin
                checks++;
                failures++;
                $display("FAIL rx_missing_ready got none expected byte=%0h by cycle %0d", rxq[rx_rd].b, rxq[rx_rd].due);
                rx_rd++;
            end
            chk("data_out", 16'(data_out), 16'(rx_last));
        end
    end

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int bitlen, input int stoplen);
        logic [9:0] fr;
        rx_exp_t    e;
        fr = {stop_bit, b, 1'b0};
        e.b   = b;
        e.due = cyc + 1 + RX_LAT;
`ifdef UART_STOP_CHECK_EN
        if (stop_bit) rxq.push_back(e);
`else
        rxq.push_back(e);
`endif
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat ((i == 9) ? stoplen : bitlen) @(negedge clk);
        end
        rx = 1'b1;
        repeat (bitlen) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < FRAME + 10) begin
            @(negedge clk);
            n++;
        end
        chk("tx_idle_timeout", 16'(busy), 16'd0);
    endtask

    int         n;
    int         rc;
    logic [9:0] cells;

    initial begin
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_tx", 16'(tx), 16'd1);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_data_out", 16'(data_out), 16'h00);
        chk("reset_data_ready", 16'(data_ready), 16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // TX 0xA5: record the centre of each bit cell and the busy length
        data_in = 8'hA5;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        data_in = 8'h3C;
        n = 0;
        cells = 10'd0;
        while (busy && n < FRAME + 100) begin
            if (n % CPB == CPB / 2 && n / CPB < 10) cells[n / CPB] = tx;
            n++;
            @(negedge clk);
        end
        chk("tx_a5_busy_cycles", 16'(n), 16'(FRAME));
        chk("tx_a5_bit_cells", 16'(cells), 16'(10'b1101001010));
        repeat (10) @(negedge clk);

        // RX 0xA5
        rc = ready_cnt;
        rx_frame(8'hA5, 1'b1, CPB, CPB);
        repeat (100) @(negedge clk);
        chk("rx_a5_data_out", 16'(data_out), 16'hA5);
        chk("rx_a5_pulses", 16'(ready_cnt - rc), 16'd1);

        // Glitch of 100 cycles must not produce a byte
        rc = ready_cnt;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (5000) @(negedge clk);
        chk("glitch_pulses", 16'(ready_cnt - rc), 16'd0);

        // Full duplex with an ignored mid-frame send
        rc = ready_cnt;
        fork
            begin
                data_in = 8'hA5;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
                repeat (2000) @(negedge clk);
                data_in = 8'h3C;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
            rx_frame(8'h5A, 1'b1, CPB, CPB);
        join
        wait_idle();
        chk("duplex_rx_data_out", 16'(data_out), 16'h5A);
        chk("duplex_rx_pulses", 16'(ready_cnt - rc), 16'd1);

        // 0x81 with a low stop bit
        rc = ready_cnt;
        rx_frame(8'h81, 1'b0, CPB, 300);
        repeat (200) @(negedge clk);
`ifdef UART_STOP_CHECK_EN
        chk("badstop_data_out", 16'(data_out), 16'h5A);
        chk("badstop_pulses", 16'(ready_cnt - rc), 16'd0);
`else
        chk("badstop_data_out", 16'(data_out), 16'h81);
        chk("badstop_pulses", 16'(ready_cnt - rc), 16'd1);
`endif

        // Random bytes both ways with up to ~2% baud skew on the incoming line
        for (int it = 0; it < 6; it++) begin
            fork
                begin
                    repeat ($urandom_range(0, 50)) @(negedge clk);
                    data_in = 8'($urandom);
                    send = 1'b1;
                    repeat ($urandom_range(1, 3)) begin
                        @(negedge clk);
                        data_in = 8'($urandom);
                    end
                    send = 1'b0;
                    repeat ($urandom_range(100, 3000)) @(negedge clk);
                    send = 1'b1;
                    @(negedge clk);
                    send = 1'b0;
                end
                begin
                    int bl;
                    bl = $urandom_range(426, 442);
                    rx_frame(8'($urandom), 1'b1, bl, bl);
                end
            join
        end

        // send held high: back-to-back frames with no idle cycle beyond busy low
        wait_idle();
        send = 1'b1;
        for (int i = 0; i < FRAME + 20; i++) begin
            data_in = 8'($urandom);
            @(negedge clk);
        end
        send = 1'b0;

        // Reset in the middle of a TX frame
        wait_idle();
        data_in = 8'h00;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_tx", 16'(tx), 16'd1);
        chk("midreset_busy", 16'(busy), 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midreset_data_out", 16'(data_out), 16'h00);

        rx_frame(8'h3C, 1'b1, CPB, CPB);
        repeat (200) @(negedge clk);
        chk("post_reset_rx", 16'(data_out), 16'h3C);

        repeat (100) @(negedge clk);
        chk("rx_pending_frames", 16'(rxq.size() - rx_rd), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
